// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor: operand capture, unpack/align,
// add/normalise, round/pack. Denormals flush to zero; round to nearest even.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M1  = MAN_W + 1;
  localparam int XW  = MAN_W + 4;
  localparam int SHW = $clog2(XW) + 1;
  localparam int EW  = EXP_W + SHW + 1;
  localparam logic [EXP_W-1:0]        EMAX  = '1;
  localparam logic signed [EW-1:0]    ETOP  = EW'(EMAX);
  localparam logic signed [EW-1:0]    EZERO = '0;
  localparam logic signed [EW-1:0]    EONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic         v0, r0_sub;
  logic [W-1:0] r0_a, r0_b;

  logic         s1_v, s1_sign, s1_sub, s1_zsign, s1_spec, s1_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [M1-1:0]    s1_mbig;
  logic [XW-1:0]    s1_small;
  logic [W-1:0]     s1_spec_res;

  logic         s2_v, s2_sign, s2_zero, s2_zsign, s2_spec, s2_inv;
  logic signed [EW-1:0] s2_exp;
  logic [M1-1:0] s2_mant;
  logic [2:0]    s2_grs;
  logic [W-1:0]  s2_spec_res;

  function automatic logic [SHW-1:0] lzc(input logic [XW-1:0] v);
    logic [SHW-1:0] n;
    n = SHW'(XW);
    for (int i = 0; i < XW; i++)
      if (v[i]) n = SHW'(XW - 1 - i);
    return n;
  endfunction

  // Stage 1: decode, flush denormals, order by magnitude, align the smaller operand.
  logic sa, sbe, a_nan, b_nan, a_inf, b_inf, big_sign;
  logic [W-2:0] mag_a, mag_b, mag_big, mag_small;
  logic [EXP_W-1:0] exp_diff;
  logic [SHW-1:0] shamt;
  logic [2*MAN_W+3:0] wide;
  logic [XW-1:0] c1_small;
  logic c1_spec, c1_inv;
  logic [W-1:0] c1_spec_res;

  always_comb begin
    sa    = r0_a[W-1];
    sbe   = r0_b[W-1] ^ r0_sub;
    a_inf = (r0_a[W-2:MAN_W] == EMAX) && (r0_a[MAN_W-1:0] == '0);
    a_nan = (r0_a[W-2:MAN_W] == EMAX) && (r0_a[MAN_W-1:0] != '0);
    b_inf = (r0_b[W-2:MAN_W] == EMAX) && (r0_b[MAN_W-1:0] == '0);
    b_nan = (r0_b[W-2:MAN_W] == EMAX) && (r0_b[MAN_W-1:0] != '0);
    mag_a = (r0_a[W-2:MAN_W] == '0) ? '0 : r0_a[W-2:0];
    mag_b = (r0_b[W-2:MAN_W] == '0) ? '0 : r0_b[W-2:0];
    if (mag_b > mag_a) begin
      mag_big = mag_b; mag_small = mag_a; big_sign = sbe;
    end else begin
      mag_big = mag_a; mag_small = mag_b; big_sign = sa;
    end
    exp_diff = mag_big[W-2:MAN_W] - mag_small[W-2:MAN_W];
    shamt    = (32'(exp_diff) > MAN_W + 3) ? SHW'(MAN_W + 3) : SHW'(exp_diff);
    wide     = {(mag_small[W-2:MAN_W] != '0), mag_small[MAN_W-1:0], {(MAN_W+3){1'b0}}} >> shamt;
    c1_small = {wide[2*MAN_W+3:MAN_W+1], |wide[MAN_W:0]};

    c1_spec     = 1'b0;
    c1_inv      = 1'b0;
    c1_spec_res = QNAN;
    if (a_nan || b_nan) begin
      c1_spec = 1'b1;
    end else if (a_inf && b_inf && (sa != sbe)) begin
      c1_spec = 1'b1;
      c1_inv  = 1'b1;
    end else if (a_inf) begin
      c1_spec     = 1'b1;
      c1_spec_res = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1_spec     = 1'b1;
      c1_spec_res = {sbe, EMAX, {MAN_W{1'b0}}};
    end
  end

  // Stage 2: the swap guarantees a non-negative difference, so no sign fix-up is needed.
  logic [XW:0] sum;
  logic [SHW-1:0] lz;
  logic [XW-1:0] c2_norm;
  logic signed [EW-1:0] c2_exp;
  logic c2_zero;

  always_comb begin
    if (s1_sub) sum = {1'b0, s1_mbig, 3'b000} - {1'b0, s1_small};
    else        sum = {1'b0, s1_mbig, 3'b000} + {1'b0, s1_small};
    lz      = lzc(sum[XW-1:0]);
    c2_zero = (sum == '0);
    c2_exp  = $signed(EW'(s1_exp));
    if (sum[XW]) begin
      c2_norm = {sum[XW:2], sum[1] | sum[0]};
      c2_exp  = c2_exp + EONE;
    end else begin
      c2_norm = sum[XW-1:0] << lz;
      c2_exp  = c2_exp - $signed(EW'(lz));
    end
  end

  // Stage 3: round to nearest even, then saturate to Inf or flush to zero.
  logic rup, inexact;
  logic [M1:0] mr;
  logic signed [EW-1:0] e3;
  logic [MAN_W-1:0] frac3;
  logic [W-1:0] c3_res;
  logic [3:0] c3_flags;

  always_comb begin
    inexact = |s2_grs;
    rup     = s2_grs[2] & (s2_grs[1] | s2_grs[0] | s2_mant[0]);
    mr      = {1'b0, s2_mant} + {{M1{1'b0}}, rup};
    e3      = s2_exp;
    frac3   = mr[MAN_W-1:0];
    if (mr[M1]) begin
      e3    = s2_exp + EONE;
      frac3 = '0;
    end
    c3_res   = {s2_sign, e3[EXP_W-1:0], frac3};
    c3_flags = {3'b000, inexact};
    if (s2_spec) begin
      c3_res   = s2_spec_res;
      c3_flags = {s2_inv, 3'b000};
    end else if (s2_zero) begin
      c3_res   = {s2_zsign, {(W-1){1'b0}}};
      c3_flags = 4'b0000;
    end else if (e3 >= ETOP) begin
      c3_res   = {s2_sign, EMAX, {MAN_W{1'b0}}};
      c3_flags = 4'b0101;
    end else if (e3 <= EZERO) begin
      c3_res   = {s2_sign, {(W-1){1'b0}}};
      c3_flags = 4'b0011;
    end
  end

  // Every rank moves together on adv, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0; r0_a <= '0; r0_b <= '0; r0_sub <= 1'b0;
      s1_v <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_zsign <= 1'b0;
      s1_spec <= 1'b0; s1_inv <= 1'b0; s1_exp <= '0; s1_mbig <= '0;
      s1_small <= '0; s1_spec_res <= '0;
      s2_v <= 1'b0; s2_sign <= 1'b0; s2_zero <= 1'b0; s2_zsign <= 1'b0;
      s2_spec <= 1'b0; s2_inv <= 1'b0; s2_exp <= '0; s2_mant <= '0;
      s2_grs <= '0; s2_spec_res <= '0;
      out_valid <= 1'b0; result <= '0; flags <= '0;
    end else if (adv) begin
      v0     <= in_valid;
      r0_a   <= a;
      r0_b   <= b;
      r0_sub <= op_sub;

      s1_v        <= v0;
      s1_sign     <= big_sign;
      s1_sub      <= sa ^ sbe;
      s1_zsign    <= sa & sbe;
      s1_spec     <= c1_spec;
      s1_inv      <= c1_inv;
      s1_exp      <= mag_big[W-2:MAN_W];
      s1_mbig     <= {(mag_big[W-2:MAN_W] != '0), mag_big[MAN_W-1:0]};
      s1_small    <= c1_small;
      s1_spec_res <= c1_spec_res;

      s2_v        <= s1_v;
      s2_sign     <= s1_sign;
      s2_zero     <= c2_zero;
      s2_zsign    <= s1_zsign;
      s2_spec     <= s1_spec;
      s2_inv      <= s1_inv;
      s2_exp      <= c2_exp;
      s2_mant     <= c2_norm[XW-1:3];
      s2_grs      <= c2_norm[2:0];
      s2_spec_res <= s1_spec_res;

      out_valid <= s2_v;
      result    <= c3_res;
      flags     <= c3_flags;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: arithmetic, rounding, specials, stall and reset.
module tb_fp_add_pipe;
  logic        clk, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int total = 0;
  int bad = 0;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated op: checks acceptance, no early output, and the N+3 result.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic vsub,
                               input logic [31:0] expRes, input logic [3:0] expFlags,
                               input string tag);
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb; op_sub = vsub;
    #1 checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, " early valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " flags"}, 32'(flags), 32'(expFlags));
  endtask

  logic [31:0] bpA [6] = '{32'h40500000, 32'hC1C40000, 32'hC1C40000, 32'h3F800000, 32'h3F800001, 32'h3F800000};
  logic [31:0] bpB [6] = '{32'h3FC00000, 32'h41CE0000, 32'hC1CE0000, 32'h34000000, 32'h33800000, 32'h3F800000};
  logic        bpS [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] bpR [6] = '{32'h40980000, 32'h3FA00000, 32'hC2490000, 32'h3F800001, 32'h3F800002, 32'h00000000};
  logic [31:0] got [$];
  logic [31:0] held;
  logic [3:0]  heldFlags;
  int sent;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
    #2;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset flags", 32'(flags), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    #16 rst_n = 1'b1;

    applyStimulus(32'h40500000, 32'h3FC00000, 1'b0, 32'h40980000, 4'b0000, "add 3.25+1.5");
    applyStimulus(32'hC1C40000, 32'h41CE0000, 1'b0, 32'h3FA00000, 4'b0000, "mixed sign");
    applyStimulus(32'hC1C40000, 32'hC1CE0000, 1'b0, 32'hC2490000, 4'b0000, "both neg");
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "1-1 zero");
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie even");
    applyStimulus(32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 4'b0000, "ulp add");
    applyStimulus(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie odd");
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, "inf-inf");
    applyStimulus(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "nan in");
    applyStimulus(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011, "underflow");
    applyStimulus(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000, "inf minus 1");

    $display("[TB] backpressure stream");
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 7);
      #1;
      checkOutput($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'(!(c >= 4 && c <= 7)));
      if (sent < 6 && in_ready) begin
        in_valid = 1'b1; a = bpA[sent]; b = bpB[sent]; op_sub = bpS[sent];
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (c == 4) begin
        held = result;
        heldFlags = flags;
        checkOutput("bp stall valid", 32'(out_valid), 32'd1);
      end else if (c > 4 && c <= 7) begin
        checkOutput($sformatf("bp hold result c%0d", c), result, held);
        checkOutput($sformatf("bp hold flags c%0d", c), 32'(flags), 32'(heldFlags));
      end
      if (out_valid && out_ready) got.push_back(result);
    end
    in_valid = 1'b0;
    checkOutput("bp count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) checkOutput($sformatf("bp order %0d", i), got[i], bpR[i]);

    $display("[TB] async reset with ops in flight");
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h33800000; op_sub = 1'b0;
    @(negedge clk);
    a = 32'h40500000; b = 32'h3FC00000;
    @(negedge clk);
    a = 32'hC1C40000; b = 32'h41CE0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset valid", 32'(out_valid), 32'd1);
    checkOutput("pre-reset result", result, 32'h3F800000);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset result", result, 32'd0);
    checkOutput("mid reset flags", 32'(flags), 32'd0);
    #7 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post reset idle %0d", k), 32'(out_valid), 32'd0);
    end
    applyStimulus(32'h40500000, 32'h3FC00000, 1'b0, 32'h40980000, 4'b0000, "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
